// File: rtl/logic_unit_arbiter_if.sv
// Request, result and status bundle between two requesters/one consumer and the arbiter.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] ina0;
    logic [WIDTH-1:0] inb0;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] ina1;
    logic [WIDTH-1:0] inb1;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_id;
    logic             out_ready;
    logic             busy;
    logic [7:0]       done_cnt;

    modport master (
        output req0_valid, req0_op, ina0, inb0,
        output req1_valid, req1_op, ina1, inb1,
        output out_ready,
        input  req0_ready, req1_ready, out, out_valid, out_id, busy, done_cnt
    );

    modport slave (
        input  req0_valid, req0_op, ina0, inb0,
        input  req1_valid, req1_op, ina1, inb1,
        input  out_ready,
        output req0_ready, req1_ready, out, out_valid, out_id, busy, done_cnt
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter feeding a one-deep logic unit; grant priority rotates
// to the requester that did not own the most recently consumed result.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic             id_q, id_d, out_id_q, out_id_d;
    logic             out_valid_q, out_valid_d, prio_q, prio_d;
    logic [7:0]       done_cnt_q, done_cnt_d;
    logic             grant_vld_s, grant_id_s, ready0_s, ready1_s;

    function automatic logic [WIDTH-1:0] alu_f(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   alu_f = a & b;
            2'b01:   alu_f = a | b;
            2'b10:   alu_f = a ^ b;
            2'b11:   alu_f = a & ~b;
            default: alu_f = {WIDTH{1'b0}};
        endcase
    endfunction

    // Combinational grant; ready is suppressed outside IDLE and while reset is held
    always_comb begin
        grant_vld_s = bus.req0_valid | bus.req1_valid;
        ready0_s    = 1'b0;
        ready1_s    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id_s = prio_q;
        end else if (bus.req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        if ((state_q == ST_IDLE) && !rst && grant_vld_s) begin
            ready0_s = ~grant_id_s;
            ready1_s = grant_id_s;
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        out_d       = out_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        prio_d      = prio_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    op_d    = grant_id_s ? bus.req1_op : bus.req0_op;
                    a_d     = grant_id_s ? bus.ina1    : bus.ina0;
                    b_d     = grant_id_s ? bus.inb1    : bus.inb0;
                    id_d    = grant_id_s;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                out_d       = alu_f(op_q, a_q, b_q);
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    prio_d      = ~out_id_q;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            id_q        <= 1'b0;
            out_q       <= {WIDTH{1'b0}};
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
            prio_q      <= 1'b0;
            done_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            out_q       <= out_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            prio_q      <= prio_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.out        = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.busy       = (state_q == ST_EXEC) | (state_q == ST_DONE);
    assign bus.done_cnt   = done_cnt_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: grant, latency, backpressure, reset and wrap scenarios.
module tb_logic_unit_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    logic_unit_arbiter_if #(.WIDTH(8)) bus ();

    logic_unit_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        checks++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
        checks++; if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", bus.out); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_id !== 1'b0) begin fails++; $display("FAIL reset_out_id: got %b want 0", bus.out_id); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done_cnt !== 8'd0) begin fails++; $display("FAIL reset_done_cnt: got %0d want 0", bus.done_cnt); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_hold: busy %b ready0 %b want 0 0", bus.busy, bus.req0_ready); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        bus.req0_op = 2'b00; bus.ina0 = 8'hF0; bus.inb0 = 8'h3C;
        bus.req0_valid = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL single_grant: ready0 %b ready1 %b want 1 0", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_exec: busy %b out_valid %b want 1 0", bus.busy, bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out !== 8'h30 || bus.out_id !== 1'b0) begin fails++; $display("FAIL single_result: valid %b out %h id %b want 1 30 0", bus.out_valid, bus.out, bus.out_id); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out !== 8'h30) begin fails++; $display("FAIL single_after: valid %b out %h want 0 30", bus.out_valid, bus.out); end
        checks++; if (bus.done_cnt !== 8'd1 || bus.busy !== 1'b0) begin fails++; $display("FAIL single_cnt: done_cnt %0d busy %b want 1 0", bus.done_cnt, bus.busy); end
    endtask

    task automatic test_alternate();
        logic       want_id;
        logic [7:0] want_out;
        apply_reset();
        bus.req0_op = 2'b01; bus.ina0 = 8'h0F; bus.inb0 = 8'hA0;
        bus.req1_op = 2'b10; bus.ina1 = 8'hFF; bus.inb1 = 8'h55;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            want_id  = (k % 2 == 1);
            want_out = want_id ? 8'hAA : 8'hAF;
            checks++; if (bus.req0_ready !== ~want_id || bus.req1_ready !== want_id) begin fails++; $display("FAIL alt_grant[%0d]: ready0 %b ready1 %b want %b %b", k, bus.req0_ready, bus.req1_ready, ~want_id, want_id); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out !== want_out || bus.out_id !== want_id) begin fails++; $display("FAIL alt_result[%0d]: valid %b out %h id %b want 1 %h %b", k, bus.out_valid, bus.out, bus.out_id, want_out, want_id); end
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.req1_op = 2'b11; bus.ina1 = 8'hCC; bus.inb1 = 8'h0A;
        bus.req1_valid = 1'b1;
        bus.out_ready  = 1'b0;
        #1;
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin fails++; $display("FAIL bp_grant: ready0 %b ready1 %b want 0 1", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out !== 8'hC4 || bus.out_id !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d]: valid %b out %h id %b want 1 c4 1", i, bus.out_valid, bus.out, bus.out_id); end
            checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL bp_ready[%0d]: ready0 %b ready1 %b busy %b want 0 0 1", i, bus.req0_ready, bus.req1_ready, bus.busy); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.done_cnt !== 8'd1 || bus.out !== 8'hC4) begin fails++; $display("FAIL bp_complete: valid %b done_cnt %0d out %h want 0 1 c4", bus.out_valid, bus.done_cnt, bus.out); end
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL bp_prio: ready0 %b ready1 %b want 1 0", bus.req0_ready, bus.req1_ready); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_capture();
        apply_reset();
        bus.req0_op = 2'b00; bus.ina0 = 8'hAA; bus.inb0 = 8'h0F;
        bus.req0_valid = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.ina0 = 8'h00; bus.inb0 = 8'hFF; bus.req0_op = 2'b01;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out !== 8'h0A) begin fails++; $display("FAIL capture_result: valid %b out %h want 1 0a", bus.out_valid, bus.out); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req0_op = 2'b00; bus.ina0 = 8'hF0; bus.inb0 = 8'h3C;
        bus.req0_valid = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.done_cnt !== 8'd1) begin fails++; $display("FAIL mid_pre_cnt: got %0d want 1", bus.done_cnt); end
        bus.req0_op = 2'b01; bus.ina0 = 8'h0F; bus.inb0 = 8'hA0;
        bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_exec: busy %b want 1", bus.busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.done_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset: valid %b out %h busy %b cnt %0d want 0 00 0 0", bus.out_valid, bus.out, bus.busy, bus.done_cnt); end
        checks++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ready: got %b want 0", bus.req0_ready); end
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL mid_discard[%0d]: valid %b busy %b want 0 0", i, bus.out_valid, bus.busy); end
        end
    endtask

    task automatic test_wrap();
        int pulses;
        apply_reset();
        pulses = 0;
        bus.req0_op = 2'b10; bus.ina0 = 8'h12; bus.inb0 = 8'h34;
        bus.req0_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 768; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        bus.req0_valid = 1'b0;
        checks++; if (pulses != 256) begin fails++; $display("FAIL wrap_pulses: got %0d want 256", pulses); end
        checks++; if (bus.done_cnt !== 8'd0) begin fails++; $display("FAIL wrap_cnt: got %0d want 0", bus.done_cnt); end
        checks++; if (bus.out !== 8'h26) begin fails++; $display("FAIL wrap_out: got %h want 26", bus.out); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.ina0 = 8'h00; bus.inb0 = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.ina1 = 8'h00; bus.inb1 = 8'h00;
        bus.out_ready  = 1'b0;
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_capture();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
